// File: rtl/decoder_dense_acc.sv
// decoder_dense_acc: bias-seeded product accumulator with round-half-up requantization, ReLU and saturation
module decoder_dense_acc #(
    parameter int PROD_W  = 26,
    parameter int ACC_W   = 32,
    parameter int OUT_W   = 16,
    parameter int SHIFT   = 8,
    parameter int RELU_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic signed [PROD_W-1:0] prod_data,
    input  logic signed [PROD_W-1:0] prod_bias,
    input  logic                     prod_last,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    output logic signed [OUT_W-1:0]  res_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [CNT_W-1:0]         beat_cnt,
    output logic [CNT_W-1:0]         neuron_cnt,
    output logic                     acc_sat
);
    localparam logic signed [ACC_W-1:0] AMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] AMIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   RND  = (ACC_W+1)'((2**SHIFT) / 2);
    localparam logic signed [ACC_W:0]   OMAX = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0]   OMIN = (ACC_W+1)'(-(2**(OUT_W-1)));
    typedef enum logic {FIRST, ACCUM} state_t;
    state_t state;
    logic signed [ACC_W-1:0] acc, base, acc_n;
    logic signed [ACC_W:0] sum, rq, rs, rc;
    logic ovf, beat;
    assign prod_ready = !res_valid || res_ready;
    assign beat = prod_valid && prod_ready;
    always_comb begin
        base  = state == FIRST ? ACC_W'(prod_bias) : acc;
        sum   = (ACC_W+1)'(base) + (ACC_W+1)'(prod_data);
        ovf   = sum[ACC_W] != sum[ACC_W-1];
        acc_n = ovf ? (sum[ACC_W] ? AMIN : AMAX) : ACC_W'(sum);
        rq    = (ACC_W+1)'(acc_n) + RND;
        rs    = rq >>> SHIFT;
        rc    = (RELU_EN != 0 && rs < 0) ? (ACC_W+1)'(0) : rs > OMAX ? OMAX : rs < OMIN ? OMIN : rs;
    end
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state      <= FIRST;
            acc        <= '0;
            res_data   <= '0;
            res_valid  <= 1'b0;
            beat_cnt   <= '0;
            neuron_cnt <= '0;
            acc_sat    <= 1'b0;
        end else begin
            if (res_valid && res_ready) neuron_cnt <= neuron_cnt + 1'b1;
            if (beat) begin
                acc_sat  <= acc_sat || ovf;
                state    <= prod_last ? FIRST : ACCUM;
                beat_cnt <= prod_last ? '0 : beat_cnt + 1'b1;
                if (prod_last) res_data <= OUT_W'(rc);
                else acc <= acc_n;
            end
            res_valid <= (beat && prod_last) || (res_valid && !res_ready);
        end
    end
endmodule
